qsort_wb_master: RTL and testbench

Wishbone initiator that drives the `qsort` sorting accelerator from a streaming data path. It accepts SIZE signed 32-bit elements on a valid/ready input stream and writes each one to the sorter's load address. It waits for the sorter's `done`, then reads the SIZE sorted elements back and presents them on a valid/ready output stream. It sits between a DMA/stream source and the sorter's Wishbone slave port, and replaces firmware-driven loading and unloading.

---
 rtl/qsort_pkg.sv | 27 ++
 rtl/qsort_wb_master_if.sv | 28 ++
 rtl/qsort_wbm_timer.sv | 41 ++++
 rtl/qsort_wb_master.sv | 169 ++++++++++++++++
 tb/tb_qsort_wb_master.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qsort_pkg.sv
// Shared definitions for the qsort accelerator and its Wishbone initiator.
// Holds the initiator state encoding, default sorter addresses, the default
// element count and the default bus timeout.
package qsort_pkg;

    localparam int unsigned QsortSize    = 10;
    localparam int unsigned QsortTimeout = 255;
    localparam logic [31:0] QsortWrAddr  = 32'h3810_0000;
    localparam logic [31:0] QsortRdAddr  = 32'h3810_0010;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StWaitDone,
        StRead,
        StDeliver,
        StDone,
        StError
    } qsort_state_e;

    // States in which the initiator waits on the sorter and may time out.
    function automatic logic is_timed(qsort_state_e s);
        return (s == StWrite) || (s == StRead) || (s == StWaitDone);
    endfunction

endpackage

// File: rtl/qsort_wb_master_if.sv
// Wishbone classic bus between the qsort initiator and the sorter slave port.
// Signals:
//   cyc, stb, we  - cycle, strobe, write enable (initiator driven)
//   sel, adr      - byte selects and address (initiator driven)
//   dat_m2s       - write data (initiator driven)
//   dat_s2m, ack  - read data and acknowledge (slave driven)
interface qsort_wb_master_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_m2s;
    logic [31:0] dat_s2m;
    logic        ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_m2s,
        input  dat_s2m, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_m2s,
        output dat_s2m, ack
    );

endinterface

// File: rtl/qsort_wbm_timer.sv
// Saturating timeout counter for the qsort Wishbone initiator.
// Ports:
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   clr_i         - clear to zero (takes priority over en_i)
//   en_i          - count up by one, holding at Timeout
//   expired_o     - high while the count equals Timeout
module qsort_wbm_timer #(
    parameter int unsigned Timeout = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned Width = (Timeout < 1) ? 1 : $clog2(Timeout + 1);
    localparam logic [Width-1:0] Limit = Width'(Timeout);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == Limit);

endmodule

// File: rtl/qsort_wb_master.sv
// Wishbone initiator that loads SIZE elements from an input stream into the
// qsort accelerator, waits for its done flag, then unloads the sorted result
// onto an output stream. Data is treated as opaque 32-bit words.
// Ports:
//   wb_clk_i, wb_rst_n_i      - clock, asynchronous active-low reset
//   start_i                   - start request, honoured only when idle
//   in_valid_i/in_data_i/in_ready_o    - input element stream
//   out_valid_o/out_data_o/out_ready_i - sorted element stream
//   sort_done_i               - sorter done flag
//   wbm                       - Wishbone classic initiator port
//   busy_o, done_o, error_o   - status flags
module qsort_wb_master
    import qsort_pkg::*;
#(
    parameter int unsigned SIZE    = QsortSize,
    parameter logic [31:0] WR_ADDR = QsortWrAddr,
    parameter logic [31:0] RD_ADDR = QsortRdAddr,
    parameter int unsigned TIMEOUT = QsortTimeout
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      start_i,
    input  logic                      in_valid_i,
    input  logic [31:0]               in_data_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    output logic [31:0]               out_data_o,
    input  logic                      out_ready_i,
    input  logic                      sort_done_i,
    qsort_wb_master_if.master         wbm,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);

    localparam int unsigned CntW = $clog2(SIZE + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(SIZE - 1);

    qsort_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            expired;
    logic            bus_d;

    // Registered Moore outputs.
    logic        cyc_q, stb_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic        in_ready_q, out_valid_q, busy_q, done_q, error_q;

    // Timer restarts on every state change and only runs in states that wait on the sorter.
    qsort_wbm_timer #(
        .Timeout (TIMEOUT)
    ) u_timer (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_n_i),
        .clr_i     (state_d != state_q),
        .en_i      (is_timed(state_q)),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end
            end
            StFetch: begin
                if (in_valid_i) begin
                    data_d  = in_data_i;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // An ack in the same cycle the timer expires still completes the write.
                if (wbm.ack) begin
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        state_d = StWaitDone;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StFetch;
                    end
                end else if (expired) begin
                    state_d = StError;
                end
            end
            StWaitDone: begin
                if (sort_done_i) begin
                    state_d = StRead;
                end else if (expired) begin
                    state_d = StError;
                end
            end
            StRead: begin
                if (wbm.ack) begin
                    data_d  = wbm.dat_s2m;
                    state_d = StDeliver;
                end else if (expired) begin
                    state_d = StError;
                end
            end
            StDeliver: begin
                if (out_ready_i) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LastIdx) ? StDone : StRead;
                end
            end
            // The sorter cannot be re-armed without reset, so both ends are sticky.
            StDone, StError: ;
            default: state_d = StIdle;
        endcase
        bus_d = (state_d == StWrite) || (state_d == StRead);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            data_q      <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            cyc_q       <= bus_d;
            stb_q       <= bus_d;
            we_q        <= (state_d == StWrite);
            sel_q       <= bus_d ? 4'hF : 4'h0;
            adr_q       <= (state_d == StWrite) ? WR_ADDR :
                           (state_d == StRead)  ? RD_ADDR : '0;
            in_ready_q  <= (state_d == StFetch);
            out_valid_q <= (state_d == StDeliver);
            busy_q      <= !((state_d == StIdle) || (state_d == StDone) ||
                             (state_d == StError));
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StError);
        end
    end

    assign wbm.cyc     = cyc_q;
    assign wbm.stb     = stb_q;
    assign wbm.we      = we_q;
    assign wbm.sel     = sel_q;
    assign wbm.adr     = adr_q;
    assign wbm.dat_m2s = data_q;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_qsort_wb_master.sv
// Self-checking bench for qsort_wb_master with a behavioural sorter slave.
module tb_qsort_wb_master;
    import qsort_pkg::*;

    localparam int unsigned SIZE    = 10;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [31:0] WR      = 32'h3810_0000;
    localparam logic [31:0] RD      = 32'h3810_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        sort_done;
    logic        busy, done, error;
    logic        ack_force = 1'b0;

    always #5 clk = ~clk;

    qsort_wb_master_if bus();

    qsort_wb_master #(
        .SIZE    (SIZE),
        .WR_ADDR (WR),
        .RD_ADDR (RD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .sort_done_i (sort_done),
        .wbm         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    // Behavioural sorter: registered write ack, combinational read ack.
    logic        ack_w = 1'b0;
    logic        sdone = 1'b0;
    int          wr_n = 0, rd_n = 0, dly = 0, wr_good = 0, rd_good = 0;
    int          stall_idx = -1;
    int          sq[$];
    logic [31:0] smem [SIZE];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_w   <= 1'b0;
            sdone   <= 1'b0;
            wr_n    <= 0;
            rd_n    <= 0;
            dly     <= 0;
            wr_good <= 0;
            rd_good <= 0;
            sq.delete();
        end else begin
            ack_w <= bus.cyc && bus.stb && bus.we && !ack_w && (wr_n != stall_idx);
            if (ack_w) begin
                sq.push_back(int'(bus.dat_m2s));
                wr_n <= wr_n + 1;
                if (bus.adr == WR && bus.sel == 4'hF) wr_good <= wr_good + 1;
            end
            if (wr_n == SIZE && !sdone) begin
                dly <= dly + 1;
                if (dly == 3) begin
                    sq.sort();
                    for (int i = 0; i < SIZE; i++) smem[i] <= sq[i];
                    sdone <= 1'b1;
                end
            end
            if (bus.cyc && bus.stb && !bus.we && sdone) begin
                rd_n <= rd_n + 1;
                if (bus.adr == RD && bus.sel == 4'hF) rd_good <= rd_good + 1;
            end
        end
    end

    assign sort_done   = sdone;
    assign bus.ack     = ack_w | (bus.cyc & bus.stb & ~bus.we & sdone) | ack_force;
    assign bus.dat_s2m = (rd_n < SIZE) ? smem[rd_n] : 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input int v, input int gap);
        bit hs;
        int n;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 400) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) chk("fetch_wait", 32'(hs), 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic run_sort(input string tag, input int vals[$], input bit bp);
        int          exp[$];
        int          got[$];
        bit          held_v;
        logic [31:0] held;
        int          n;
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (vals[i]) push(vals[i], bp ? int'($urandom_range(0, 4)) : 0);
        held_v = 1'b0;
        held = '0;
        n = 0;
        while (got.size() < SIZE && n < 5000) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (held_v) chk({tag, "_hold"}, out_data, held);
                if (out_ready) begin
                    got.push_back(int'(out_data));
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held   = out_data;
                end
            end else begin
                held_v = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        exp = vals;
        exp.sort();
        chk({tag, "_count"}, 32'(got.size()), 32'(SIZE));
        for (int i = 0; i < SIZE && i < got.size(); i++) begin
            chk($sformatf("%s_out%0d", tag, i), got[i], exp[i]);
        end
        chk({tag, "_done"}, 32'(done), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_writes"}, 32'(wr_good), 32'(SIZE));
        chk({tag, "_reads"}, 32'(rd_good), 32'(SIZE));
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_cyc"}, 32'(bus.cyc), 32'h0);
        chk({tag, "_stb"}, 32'(bus.stb), 32'h0);
        chk({tag, "_we"}, 32'(bus.we), 32'h0);
        chk({tag, "_sel"}, 32'(bus.sel), 32'h0);
        chk({tag, "_adr"}, bus.adr, 32'h0);
    endtask

    initial begin
        int v[$];
        int n;

        // Reset values.
        reset_dut();
        chk_idle_bus("rst");
        chk("rst_dat", bus.dat_m2s, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_flags", {29'h0, busy, done, error}, 32'h0);

        // Acks while idle do nothing.
        ack_force = 1'b1;
        repeat (2) tick();
        ack_force = 1'b0;
        chk_idle_bus("idle_ack");
        chk("idle_ack_busy", 32'(busy), 32'h0);
        chk("idle_ack_in_ready", 32'(in_ready), 32'h0);

        // Enter FETCH, then poke start and ack: still fetching, no bus activity.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fetch_in_ready", 32'(in_ready), 32'h1);
        chk("fetch_busy", 32'(busy), 32'h1);
        start = 1'b1;
        ack_force = 1'b1;
        tick();
        start = 1'b0;
        ack_force = 1'b0;
        chk("fetch_misuse_in_ready", 32'(in_ready), 32'h1);
        chk_idle_bus("fetch_misuse");

        // Nominal (its start pulse lands in FETCH and is ignored).
        v = '{893, 40, 3233, 4267, 2669, 2541, 9073, 6023, 5681, 4622};
        run_sort("nom", v, 1'b0);

        // start and acks in DONE are ignored.
        start = 1'b1;
        ack_force = 1'b1;
        tick();
        start = 1'b0;
        ack_force = 1'b0;
        tick();
        chk("done_sticky", 32'(done), 32'h1);
        chk("done_busy", 32'(busy), 32'h0);
        chk_idle_bus("done_misuse");

        // Negatives and duplicates.
        reset_dut();
        v = '{-5, 7, -5, 0, 2147483647, int'(32'h8000_0000), 7, 1, 1, 0};
        run_sort("neg", v, 1'b0);

        // Random data with input gaps and output backpressure.
        for (int r = 0; r < 2; r++) begin
            reset_dut();
            v.delete();
            for (int i = 0; i < SIZE; i++) v.push_back(int'($urandom()));
            run_sort($sformatf("rnd%0d", r), v, 1'b1);
        end

        // Timeout on the third write.
        reset_dut();
        stall_idx = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        push(11, 0);
        push(22, 0);
        push(33, 0);
        chk("to_stb_rise", 32'(bus.stb), 32'h1);
        n = 0;
        while (!error && n < 400) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
        chk_idle_bus("to_err");
        chk("to_busy", 32'(busy), 32'h0);
        ack_force = 1'b1;
        repeat (3) tick();
        ack_force = 1'b0;
        tick();
        chk("to_sticky", 32'(error), 32'h1);
        chk("to_late_cyc", 32'(bus.cyc), 32'h0);
        chk("to_done", 32'(done), 32'h0);
        stall_idx = -1;

        // Asynchronous reset in the middle of a write.
        reset_dut();
        stall_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        push(44, 0);
        #2;
        chk("mid_pre_stb", 32'(bus.stb), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_idle_bus("mid_rst");
        chk("mid_rst_flags", {28'h0, in_ready, busy, done, error}, 32'h0);
        chk("mid_rst_out", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_data", out_data, 32'h0);
        stall_idx = -1;
        reset_dut();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
